// File: rtl/burst_memory_pkg.sv
// Shared types and default parameters for the burst memory.
package burst_memory_pkg;
   localparam int DEF_DATA_WIDTH     = 8;
   localparam int DEF_ADDR_WIDTH     = 8;
   localparam int DEF_MEMORY_DEPTH   = 256;
   localparam int DEF_LEN_WIDTH      = 8;
   localparam int DEF_CLEAR_ON_RESET = 1;

   typedef enum logic [1:0] {CLEAR, IDLE, WR_BURST, RD_BURST} state_e;

   // Which requester last loaded the RAM read register.
   typedef enum logic [1:0] {SRC_NONE, SRC_SINGLE, SRC_BURST} rd_src_e;
endpackage

// File: rtl/burst_memory_if.sv
// Single-access and DMA burst port bundle; slave side is the memory.
interface burst_memory_if
   import burst_memory_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH
);
   logic                  init_done;
   logic                  we;
   logic [ADDR_WIDTH-1:0] write_address;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  re;
   logic [ADDR_WIDTH-1:0] read_address;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  rd_valid;
   logic                  bst_start;
   logic                  bst_write;
   logic [ADDR_WIDTH-1:0] bst_addr;
   logic [LEN_WIDTH-1:0]  bst_len;
   logic                  bst_busy;
   logic                  bst_done;
   logic [DATA_WIDTH-1:0] bst_wdata;
   logic                  bst_wvalid;
   logic                  bst_wready;
   logic [DATA_WIDTH-1:0] bst_rdata;
   logic                  bst_rvalid;
   logic                  bst_rready;

   modport slave (
      output init_done, data_out, rd_valid, bst_busy, bst_done, bst_wready, bst_rdata, bst_rvalid,
      input  we, write_address, data_in, re, read_address,
      input  bst_start, bst_write, bst_addr, bst_len, bst_wdata, bst_wvalid, bst_rready
   );

   modport master (
      input  init_done, data_out, rd_valid, bst_busy, bst_done, bst_wready, bst_rdata, bst_rvalid,
      output we, write_address, data_in, re, read_address,
      output bst_start, bst_write, bst_addr, bst_len, bst_wdata, bst_wvalid, bst_rready
   );
endinterface

// File: rtl/burst_memory_sdp_ram.sv
// Simple dual-port storage: one synchronous write, one registered read-first read.
module sdp_ram
   import burst_memory_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int MEMORY_DEPTH = DEF_MEMORY_DEPTH
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);
   localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEMORY_DEPTH);

   logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  wr_in_range, rd_in_range;

   assign wr_in_range = {1'b0, wr_addr} < DEPTH;
   assign rd_in_range = {1'b0, rd_addr} < DEPTH;

   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = rd_in_range ? mem[rd_addr] : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && wr_in_range) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data_q <= rd_data_d;
   end

   assign rd_data = rd_data_q;
endmodule

// File: rtl/burst_memory.sv
// Memory with a single-access port, a wrapping DMA burst port and a clear sweep after reset.
//   state    | meaning
//   CLEAR    | zeroing one word per cycle after reset
//   IDLE     | single port active, burst requests accepted
//   WR_BURST | accepting bst_wdata beats
//   RD_BURST | issuing bst_rdata beats under valid/ready
module burst_memory
   import burst_memory_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int MEMORY_DEPTH   = DEF_MEMORY_DEPTH,
   parameter int LEN_WIDTH      = DEF_LEN_WIDTH,
   parameter int CLEAR_ON_RESET = DEF_CLEAR_ON_RESET
) (
   input logic           clk,
   input logic           rst,
   burst_memory_if.slave bus
);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEMORY_DEPTH - 1);

   state_e                state_q, state_d;
   rd_src_e               rd_src_q, rd_src_d;
   logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_inc;
   logic [LEN_WIDTH-1:0]  beats_q, beats_d;
   logic                  init_done_q, init_done_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  bst_done_q, bst_done_d;
   logic                  bst_rvalid_q, bst_rvalid_d;
   logic [DATA_WIDTH-1:0] data_out_hold_q, data_out_hold_d;
   logic [DATA_WIDTH-1:0] bst_rdata_hold_q, bst_rdata_hold_d;
   logic [DATA_WIDTH-1:0] data_out_vis, bst_rdata_vis;

   logic                  ram_we, ram_re;
   logic [ADDR_WIDTH-1:0] ram_waddr, ram_raddr;
   logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;

   sdp_ram #(
      .DATA_WIDTH  (DATA_WIDTH),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .MEMORY_DEPTH(MEMORY_DEPTH)
   ) u_ram (
      .clk    (clk),
      .wr_en  (ram_we),
      .wr_addr(ram_waddr),
      .wr_data(ram_wdata),
      .rd_en  (ram_re),
      .rd_addr(ram_raddr),
      .rd_data(ram_rdata)
   );

   // The RAM has one read register shared by both ports; whichever port did not load it
   // last shows its held copy, so each port's data stays put while the other one reads.
   assign data_out_vis  = (rd_src_q == SRC_SINGLE) ? ram_rdata : data_out_hold_q;
   assign bst_rdata_vis = (rd_src_q == SRC_BURST)  ? ram_rdata : bst_rdata_hold_q;
   assign addr_inc      = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_WIDTH'(1);

   always_comb begin
      state_d          = state_q;
      rd_src_d         = rd_src_q;
      clr_ptr_d        = clr_ptr_q;
      addr_d           = addr_q;
      beats_d          = beats_q;
      init_done_d      = init_done_q;
      rd_valid_d       = 1'b0;
      bst_done_d       = 1'b0;
      bst_rvalid_d     = bst_rvalid_q;
      data_out_hold_d  = data_out_vis;
      bst_rdata_hold_d = bst_rdata_vis;
      ram_we           = 1'b0;
      ram_waddr        = '0;
      ram_wdata        = '0;
      ram_re           = 1'b0;
      ram_raddr        = '0;
      case (state_q)
         CLEAR: begin
            ram_we    = 1'b1;
            ram_waddr = clr_ptr_q;
            clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
            if (clr_ptr_q == LAST_ADDR) begin
               init_done_d = 1'b1;
               state_d     = IDLE;
            end
         end
         IDLE: begin
            init_done_d = 1'b1;
            ram_we      = bus.we;
            ram_waddr   = bus.write_address;
            ram_wdata   = bus.data_in;
            if (bus.re) begin
               ram_re     = 1'b1;
               ram_raddr  = bus.read_address;
               rd_valid_d = 1'b1;
               rd_src_d   = SRC_SINGLE;
            end
            if (bus.bst_start) begin
               addr_d  = bus.bst_addr;
               beats_d = bus.bst_len;
               if (bus.bst_len == '0) begin
                  bst_done_d = 1'b1;
               end else begin
                  state_d = bus.bst_write ? WR_BURST : RD_BURST;
               end
            end
         end
         WR_BURST: begin
            if (bus.bst_wvalid) begin
               ram_we    = 1'b1;
               ram_waddr = addr_q;
               ram_wdata = bus.bst_wdata;
               addr_d    = addr_inc;
               beats_d   = beats_q - LEN_WIDTH'(1);
               if (beats_q == LEN_WIDTH'(1)) begin
                  bst_done_d = 1'b1;
                  state_d    = IDLE;
               end
            end
         end
         RD_BURST: begin
            if ((beats_q != '0) && (!bst_rvalid_q || bus.bst_rready)) begin
               ram_re       = 1'b1;
               ram_raddr    = addr_q;
               rd_src_d     = SRC_BURST;
               bst_rvalid_d = 1'b1;
               addr_d       = addr_inc;
               beats_d      = beats_q - LEN_WIDTH'(1);
            end else if (bus.bst_rready) begin
               bst_rvalid_d = 1'b0;
               if (bst_rvalid_q && (beats_q == '0)) begin
                  bst_done_d = 1'b1;
                  state_d    = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
         rd_src_q         <= SRC_NONE;
         clr_ptr_q        <= '0;
         addr_q           <= '0;
         beats_q          <= '0;
         init_done_q      <= 1'b0;
         rd_valid_q       <= 1'b0;
         bst_done_q       <= 1'b0;
         bst_rvalid_q     <= 1'b0;
         data_out_hold_q  <= '0;
         bst_rdata_hold_q <= '0;
      end else begin
         state_q          <= state_d;
         rd_src_q         <= rd_src_d;
         clr_ptr_q        <= clr_ptr_d;
         addr_q           <= addr_d;
         beats_q          <= beats_d;
         init_done_q      <= init_done_d;
         rd_valid_q       <= rd_valid_d;
         bst_done_q       <= bst_done_d;
         bst_rvalid_q     <= bst_rvalid_d;
         data_out_hold_q  <= data_out_hold_d;
         bst_rdata_hold_q <= bst_rdata_hold_d;
      end
   end

   assign bus.init_done  = init_done_q;
   assign bus.data_out   = data_out_vis;
   assign bus.rd_valid   = rd_valid_q;
   assign bus.bst_busy   = (state_q == WR_BURST) || (state_q == RD_BURST);
   assign bus.bst_done   = bst_done_q;
   assign bus.bst_wready = (state_q == WR_BURST);
   assign bus.bst_rdata  = bst_rdata_vis;
   assign bus.bst_rvalid = bst_rvalid_q;
endmodule

// File: tb/tb_burst_memory.sv
// Bench for burst_memory: directed plan items plus random traffic against an array model.
module tb_burst_memory;
   localparam int DW    = 8;
   localparam int AW    = 8;
   localparam int LW    = 8;
   localparam int DEPTH = 256;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   burst_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

   burst_memory #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEMORY_DEPTH(DEPTH), .LEN_WIDTH(LW), .CLEAR_ON_RESET(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int            n_vec = 0;
   int            n_err = 0;
   logic [DW-1:0] model_mem [DEPTH];
   logic [DW-1:0] last_rd = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [AW-1:0] wrap(input int a);
      return AW'(a % DEPTH);
   endfunction

   task automatic idle_inputs();
      bus.we = 1'b0; bus.write_address = '0; bus.data_in = '0;
      bus.re = 1'b0; bus.read_address = '0;
      bus.bst_start = 1'b0; bus.bst_write = 1'b0; bus.bst_addr = '0; bus.bst_len = '0;
      bus.bst_wdata = '0; bus.bst_wvalid = 1'b0; bus.bst_rready = 1'b0;
   endtask

   task automatic clear_model();
      foreach (model_mem[i]) model_mem[i] = '0;
      last_rd = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_data_out"},   bus.data_out,   0);
      chk({tag, "_rd_valid"},   bus.rd_valid,   0);
      chk({tag, "_init_done"},  bus.init_done,  0);
      chk({tag, "_busy"},       bus.bst_busy,   0);
      chk({tag, "_done"},       bus.bst_done,   0);
      chk({tag, "_wready"},     bus.bst_wready, 0);
      chk({tag, "_rdata"},      bus.bst_rdata,  0);
      chk({tag, "_rvalid"},     bus.bst_rvalid, 0);
   endtask

   task automatic wait_init(input string tag, input int already, input int exp_total);
      int edges = already;
      while (!bus.init_done && edges < 1000) begin
         tick();
         edges++;
      end
      chk({tag, "_init_edges"}, edges, exp_total);
   endtask

   task automatic single_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.we = 1'b1; bus.write_address = a; bus.data_in = d;
      tick();
      bus.we = 1'b0;
      model_mem[a] = d;
   endtask

   task automatic single_read(input logic [AW-1:0] a, input string tag);
      bus.re = 1'b1; bus.read_address = a;
      tick();
      bus.re = 1'b0;
      chk({tag, "_rd_valid"}, bus.rd_valid, 1);
      chk({tag, "_data_out"}, bus.data_out, model_mem[a]);
      last_rd = model_mem[a];
   endtask

   task automatic single_rw(input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
      bus.we = 1'b1; bus.write_address = a; bus.data_in = d;
      bus.re = 1'b1; bus.read_address = a;
      tick();
      bus.we = 1'b0; bus.re = 1'b0;
      chk({tag, "_rd_valid"}, bus.rd_valid, 1);
      chk({tag, "_old_data"}, bus.data_out, model_mem[a]);
      last_rd = model_mem[a];
      model_mem[a] = d;
   endtask

   task automatic start_burst(input bit wr, input logic [AW-1:0] a, input int len, input string tag);
      bus.bst_start = 1'b1; bus.bst_write = wr; bus.bst_addr = a; bus.bst_len = LW'(len);
      tick();
      bus.bst_start = 1'b0;
      if (len == 0) begin
         chk({tag, "_len0_done"}, bus.bst_done, 1);
         chk({tag, "_len0_busy"}, bus.bst_busy, 0);
         tick();
         chk({tag, "_len0_done2"}, bus.bst_done, 0);
         chk({tag, "_len0_busy2"}, bus.bst_busy, 0);
      end else begin
         chk({tag, "_busy"},   bus.bst_busy,   1);
         chk({tag, "_wready"}, bus.bst_wready, wr);
      end
   endtask

   task automatic burst_write(input logic [AW-1:0] a, input int len, input bit rnd,
                              input logic [DW-1:0] dbase, input int bubble_pct,
                              input int forced_bubble, input string tag);
      int            k = 0;
      int            cyc = 0;
      int            dones = 0;
      bit            acc;
      logic [DW-1:0] d;
      start_burst(1'b1, a, len, tag);
      if (len == 0) return;
      while (k < len && cyc < 200) begin
         bus.bst_wvalid = (cyc != forced_bubble) && ($urandom_range(0, 99) >= bubble_pct);
         d = rnd ? DW'($urandom) : DW'(dbase + k);
         bus.bst_wdata = d;
         acc = bus.bst_wvalid && bus.bst_wready;
         tick();
         cyc++;
         if (acc) begin
            model_mem[wrap(a + k)] = d;
            k++;
         end
         if (bus.bst_done) dones++;
         if (acc && k == len) begin
            chk({tag, "_done_last"}, bus.bst_done,   1);
            chk({tag, "_busy_end"},  bus.bst_busy,   0);
            chk({tag, "_wready_end"}, bus.bst_wready, 0);
         end
      end
      bus.bst_wvalid = 1'b0;
      chk({tag, "_beats"}, k, len);
      tick();
      if (bus.bst_done) dones++;
      chk({tag, "_done_count"}, dones, 1);
   endtask

   task automatic burst_read(input logic [AW-1:0] a, input int len, input int stall_pct,
                             input bit directed_stall, input string tag);
      int            k = 0;
      int            cyc = 0;
      int            dones = 0;
      int            stall_left = -1;
      bit            acc;
      bit            was_stalled;
      logic [DW-1:0] held;
      start_burst(1'b0, a, len, tag);
      if (len == 0) return;
      while (k < len && cyc < 300) begin
         if (directed_stall && stall_left < 0 && bus.bst_rvalid) stall_left = 3;
         if (stall_left > 0) begin
            bus.bst_rready = 1'b0;
            stall_left--;
         end else begin
            bus.bst_rready = ($urandom_range(0, 99) >= stall_pct);
         end
         acc = bus.bst_rvalid && bus.bst_rready;
         if (acc) chk({tag, "_rdata"}, bus.bst_rdata, model_mem[wrap(a + k)]);
         was_stalled = bus.bst_rvalid && !bus.bst_rready;
         held = bus.bst_rdata;
         tick();
         cyc++;
         if (was_stalled) begin
            chk({tag, "_stall_rdata"},  bus.bst_rdata,  held);
            chk({tag, "_stall_rvalid"}, bus.bst_rvalid, 1);
         end
         if (acc) k++;
         if (bus.bst_done) dones++;
         if (acc && k == len) begin
            chk({tag, "_done_last"}, bus.bst_done,   1);
            chk({tag, "_busy_end"},  bus.bst_busy,   0);
            chk({tag, "_rvalid_end"}, bus.bst_rvalid, 0);
         end
      end
      bus.bst_rready = 1'b0;
      chk({tag, "_beats"}, k, len);
      chk({tag, "_data_out_hold"}, bus.data_out, last_rd);
      tick();
      if (bus.bst_done) dones++;
      chk({tag, "_done_count"}, dones, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      clear_model();

      // Reset and clear sweep, with a write during CLEAR that must be dropped.
      rst = 1'b1;
      repeat (2) tick();
      check_reset_outputs("rst");
      rst = 1'b0;
      repeat (100) tick();
      chk("clear_init_early", bus.init_done, 0);
      bus.we = 1'b1; bus.write_address = 8'h10; bus.data_in = 8'h77;
      tick();
      bus.we = 1'b0;
      wait_init("clear", 101, 256);
      single_read(8'h00, "clr_00");
      single_read(8'h7F, "clr_7f");
      single_read(8'hFF, "clr_ff");
      single_read(8'h10, "clr_drop10");

      // Single port writes, reads, hold and read-first collision.
      for (int i = 0; i < 5; i++) single_write(AW'(i), DW'(8'hA0 + i));
      for (int i = 0; i < 5; i++) single_read(AW'(i), "single");
      tick();
      chk("hold_data_out", bus.data_out, 8'hA4);
      chk("hold_rd_valid", bus.rd_valid, 0);
      single_rw(8'h02, 8'h55, "rw02");
      single_read(8'h02, "rw02_after");

      // Wrapping burst write with a bubble, then backpressured burst read.
      burst_write(8'hFE, 4, 1'b0, 8'h11, 0, 1, "bw_wrap");
      single_read(8'hFE, "bw_fe");
      single_read(8'hFF, "bw_ff");
      single_read(8'h00, "bw_00");
      single_read(8'h01, "bw_01");
      burst_read(8'hFE, 4, 0, 1'b1, "br_stall");

      // Single access and a second start while a burst is running.
      start_burst(1'b1, 8'h60, 2, "cont");
      bus.we = 1'b1; bus.write_address = 8'h50; bus.data_in = 8'h99;
      bus.re = 1'b1; bus.read_address = 8'h00;
      bus.bst_start = 1'b1; bus.bst_write = 1'b1; bus.bst_addr = 8'h80; bus.bst_len = 8'd5;
      tick();
      chk("cont_rd_valid", bus.rd_valid, 0);
      chk("cont_busy", bus.bst_busy, 1);
      idle_inputs();
      bus.bst_wvalid = 1'b1; bus.bst_wdata = 8'h21;
      tick();
      bus.bst_wdata = 8'h22;
      tick();
      chk("cont_done", bus.bst_done, 1);
      model_mem[8'h60] = 8'h21;
      model_mem[8'h61] = 8'h22;
      bus.bst_wvalid = 1'b0;
      tick();
      chk("cont_busy_after", bus.bst_busy, 0);
      chk("cont_done_once", bus.bst_done, 0);
      single_read(8'h50, "cont_50");
      single_read(8'h80, "cont_80");
      single_read(8'h60, "cont_60");
      single_read(8'h61, "cont_61");
      start_burst(1'b1, 8'h40, 0, "len0");

      // Random traffic.
      for (int it = 0; it < 60; it++) begin
         case ($urandom_range(0, 4))
            0: single_write(AW'($urandom), DW'($urandom));
            1: single_read(AW'($urandom), "rnd_rd");
            2: single_rw(AW'($urandom), DW'($urandom), "rnd_rw");
            3: burst_write(AW'($urandom), $urandom_range(0, 10), 1'b1, 8'h00, 30, -1, "rnd_bw");
            default: burst_read(AW'($urandom), $urandom_range(0, 10), 30, 1'b0, "rnd_br");
         endcase
      end

      // Reset in the middle of a write burst.
      start_burst(1'b1, 8'h30, 8, "mid");
      bus.bst_wvalid = 1'b1; bus.bst_wdata = 8'hC1;
      tick();
      bus.bst_wdata = 8'hC2;
      tick();
      chk("mid_no_done", bus.bst_done, 0);
      idle_inputs();
      rst = 1'b1;
      tick();
      check_reset_outputs("mid_rst");
      tick();
      rst = 1'b0;
      clear_model();
      wait_init("mid", 0, 256);
      chk("mid_no_done_after", bus.bst_done, 0);
      single_read(8'h30, "mid_30");
      single_read(8'h31, "mid_31");
      single_read(8'h32, "mid_32");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/burst_memory.md
Name: burst_memory

Overview:
Parametrised successor to memory_module for the UART-DMA datapath. Keeps the single-access write/read port. Adds a DMA burst port: base address, beat count, auto-incrementing address that wraps, and valid/ready handshakes on write and read data. Replaces the one-cycle reset clear with a sequential clear sweep and reports completion through init_done.

Parameters:
DATA_WIDTH, 8, word width
ADDR_WIDTH, 8, address width
MEMORY_DEPTH, 256, number of words; must be <= 2**ADDR_WIDTH
LEN_WIDTH, 8, width of burst beat count
CLEAR_ON_RESET, 1, 1 = zero the array after reset; 0 = contents undefined, no sweep

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
init_done  out  1  high once the clear sweep is finished; stays high until next rst
we  in  1  single write enable
write_address  in  ADDR_WIDTH  single write address
data_in  in  DATA_WIDTH  single write data
re  in  1  single read enable
read_address  in  ADDR_WIDTH  single read address
data_out  out  DATA_WIDTH  single read data, registered
rd_valid  out  1  one-cycle pulse: data_out updated by the last edge
bst_start  in  1  burst request, sampled in IDLE only
bst_write  in  1  1 = burst write, 0 = burst read; sampled with bst_start
bst_addr  in  ADDR_WIDTH  burst base address
bst_len  in  LEN_WIDTH  number of beats
bst_busy  out  1  burst in progress
bst_done  out  1  one-cycle completion pulse
bst_wdata  in  DATA_WIDTH  burst write data
bst_wvalid  in  1  burst write data valid
bst_wready  out  1  high in WR_BURST
bst_rdata  out  DATA_WIDTH  burst read data
bst_rvalid  out  1  burst read data valid; held until accepted
bst_rready  in  1  consumer accepts bst_rdata

Behaviour:
- Reset (rst high at an edge):
  - state = CLEAR, or IDLE if CLEAR_ON_RESET=0.
  - Clear pointer = 0.
  - Outputs: data_out=0, rd_valid=0, init_done=0, bst_busy=0, bst_done=0, bst_wready=0, bst_rdata=0, bst_rvalid=0.
  - Reset mid-burst abandons the burst: no bst_done pulse; array is re-cleared.
- CLEAR:
  - Writes 0 to one address per cycle, from 0 to MEMORY_DEPTH-1.
  - The edge that writes MEMORY_DEPTH-1 sets init_done=1 and moves to IDLE.
  - With CLEAR_ON_RESET=0, init_done=1 the first edge after rst deasserts.
- Single-access port (active in IDLE only; ignored in CLEAR and while bst_busy):
  - we=1: mem[write_address] <= data_in at the edge.
  - re=1: data_out <= mem[read_address] at the edge; rd_valid=1 for that cycle. Latency 1.
  - re=0: data_out holds its value; rd_valid=0.
  - Same-address simultaneous read and write: read-first, returns old data.
  - Address >= MEMORY_DEPTH: write dropped; read returns 0 with rd_valid=1.
- Burst start (IDLE, bst_start=1 at an edge):
  - Latch bst_addr into the address counter and bst_len into the beat counter.
  - Go to WR_BURST or RD_BURST per bst_write; bst_busy=1 from the next cycle.
  - bst_len=0: no array access, bst_done pulses next cycle, stay IDLE.
  - bst_start outside IDLE is ignored.
- WR_BURST:
  - bst_wready=1.
  - Each edge with bst_wvalid=1: write bst_wdata to the address counter, increment the address, decrement the beat count.
- RD_BURST:
  - A beat is issued at an edge when beats remain and (bst_rvalid=0 or bst_rready=1): bst_rdata <= mem[addr], bst_rvalid=1, address++, beat count--.
  - Edge with bst_rready=1 and no new beat issued: bst_rvalid=0.
  - Throughput 1 beat/cycle with bst_rready held high. bst_rdata is stable while bst_rvalid=1 and bst_rready=0.
- Address increment wraps MEMORY_DEPTH-1 -> 0. This also holds when MEMORY_DEPTH < 2**ADDR_WIDTH.
- Completion:
  - Write: on the edge of the final accepted wdata beat.
  - Read: on the edge where the final rdata is accepted (bst_rvalid & bst_rready, no beats left).
  - At that edge: bst_done=1 for one cycle, state = IDLE, bst_busy=0 and bst_wready=0 from that cycle.

Decomposition:
- burst_memory_pkg holds:
  - state enum: CLEAR, IDLE, WR_BURST, RD_BURST.
  - default parameter constants.
- One sub-module, sdp_ram: the storage array. One synchronous write port, one synchronous read port. Read-first. Out-of-range reads return 0.
- burst_memory owns arbitration and muxes the clear, single and burst sources onto sdp_ram.

Test Plan:
- Reset clear: rst 2 cycles, release.
  - init_done rises exactly 256 edges later.
  - Reads of 0x00, 0x7F, 0xFF return 0x00.
  - we at 0x10 issued during CLEAR is dropped (0x10 still reads 0x00).
- Single port: write 0xA0..0xA4 to 0x00..0x04, then read each.
  - data_out and rd_valid one cycle after re.
  - re=0 holds 0xA4.
  - Same-cycle write 0x55 / read at 0x02 returns 0xA2; the next read returns 0x55.
- Wrapping burst write: bst_addr=0xFE, bst_len=4, data 0x11..0x14 with one wvalid bubble.
  - 0xFE=0x11, 0xFF=0x12, 0x00=0x13, 0x01=0x14.
  - bst_done once, on the fourth beat.
- Burst read with backpressure: read 4 beats from 0xFE; bst_rready low for 3 cycles after the first beat.
  - Sequence 0x11,0x12,0x13,0x14 with no loss or duplication.
  - bst_rdata held stable while stalled.
- Contention and corner cases:
  - we/re during bst_busy are ignored (no rd_valid, no array change).
  - bst_start with bst_len=0 gives bst_done the next cycle, bst_busy stays 0.
  - A second bst_start mid-burst is ignored.
- Reset mid-burst: rst asserted after 2 of 8 write beats.
  - No bst_done; all outputs 0.
  - After the sweep, the burst addresses read 0x00.
